// File: rtl/adbg_wb_burst_ctrl.sv
// -----------------------------------------------------------------------------
// adbg_wb_burst_ctrl
//
// Burst command engine for the debug WishBone path, running in the TCK domain.
// It takes one burst command (start address, word size, word count, direction),
// then issues one single-word access per word to the WishBone bus interface
// unit (BIU) over its strobe/ready handshake. Write words stream in from the
// JTAG shift logic and read words stream back out to it. The address
// auto-increments by the word size. Short words are justified to the BIU
// conventions: writes go in the upper bits, reads come back in the lower bits.
// The first bus error of a burst is recorded.
//
// Optional feature (compile-time macro ADBG_BURST_ABORT_ON_ERR_EN):
//   When defined, a completed access that reports a bus error ends the burst.
//   When undefined, the burst always runs its full count.
//
// Parameters:
//   CNT_W           width of the word-count field and remaining-word counter
//
// Ports:
//   tck_i           clock (single domain)
//   rstn_i          synchronous active-low reset
//   cmd_valid_i     burst command valid
//   cmd_ready_o     command accepted (high only while idle)
//   cmd_addr_i      start byte address
//   cmd_rd_wrn_i    1 = read burst, 0 = write burst
//   cmd_word_size_i bytes per word (1, 2, 4; anything else means 4)
//   cmd_count_i     number of words
//   wr_data_i       write word, LSB-justified
//   wr_valid_i      write word valid
//   wr_ready_o      write word consumed this cycle
//   rd_data_o       read word, LSB-justified, upper bits zero
//   rd_valid_o      read word valid
//   rd_ready_i      consumer accepts read word
//   biu_data_o      write data to BIU (short words in upper bits)
//   biu_data_i      read data from BIU (short words in lower bits)
//   biu_addr_o      access address to BIU
//   biu_rd_wrn_o    access direction to BIU
//   biu_word_size_o access size to BIU
//   biu_strobe_o    single-cycle access request to BIU
//   biu_rdy_i       BIU ready / access complete
//   biu_err_i       BIU bus error for the completed access
//   busy_o          engine not idle
//   done_o          one-cycle pulse when a burst ends
//   err_o           sticky error flag for the current/last burst
//   err_addr_o      address of the first errored word
// -----------------------------------------------------------------------------
module adbg_wb_burst_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             tck_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_addr_i,
    input  logic             cmd_rd_wrn_i,
    input  logic [2:0]       cmd_word_size_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic [31:0]      wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [31:0]      rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [31:0]      biu_data_o,
    input  logic [31:0]      biu_data_i,
    output logic [31:0]      biu_addr_o,
    output logic             biu_rd_wrn_o,
    output logic [2:0]       biu_word_size_o,
    output logic             biu_strobe_o,
    input  logic             biu_rdy_i,
    input  logic             biu_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      err_addr_o
);

`ifdef ADBG_BURST_ABORT_ON_ERR_EN
    localparam bit ABORT_ON_ERR = 1'b1;
`else
    localparam bit ABORT_ON_ERR = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PUSH,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q;
    logic               rd_wrn_q;
    logic [2:0]         size_q;
    logic [CNT_W-1:0]   remain_q;
    logic [31:0]        rd_data_q;
    logic               err_q;
    logic [31:0]        err_addr_q;
    logic               strobe;

    // Any size other than 1 or 2 bytes is handled as a full 32-bit word.
    function automatic logic [2:0] norm_size(input logic [2:0] s);
        case (s)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // The BIU expects short write words in the upper bits.
    function automatic logic [31:0] justify_wr(input logic [31:0] d, input logic [2:0] s);
        case (s)
            3'd1:    return {d[7:0], 24'h0};
            3'd2:    return {d[15:0], 16'h0};
            default: return d;
        endcase
    endfunction

    // The BIU returns short read words in the lower bits; clear stale upper lanes.
    function automatic logic [31:0] mask_rd(input logic [31:0] d, input logic [2:0] s);
        case (s)
            3'd1:    return {24'h0, d[7:0]};
            3'd2:    return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge tck_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        strobe  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i)
                    state_d = (cmd_count_i == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                // A busy BIU (rdy low, e.g. still finishing after reset) just delays issue.
                strobe = biu_rdy_i & (rd_wrn_q | wr_valid_i);
                if (strobe) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (biu_rdy_i) begin
                    // Reads always deliver their word, even an errored one.
                    if (rd_wrn_q)
                        state_d = ST_PUSH;
                    else if (remain_q == CNT_W'(1) || (ABORT_ON_ERR && biu_err_i))
                        state_d = ST_DONE;
                    else
                        state_d = ST_ISSUE;
                end
            end
            ST_PUSH: begin
                // err_q can only be set by this burst's single abort-triggering error.
                if (rd_ready_i)
                    state_d = (remain_q == '0 || (ABORT_ON_ERR && err_q)) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge tck_i) begin
        if (!rstn_i) begin
            addr_q     <= '0;
            rd_wrn_q   <= 1'b0;
            size_q     <= '0;
            remain_q   <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q     <= cmd_addr_i;
                        rd_wrn_q   <= cmd_rd_wrn_i;
                        size_q     <= norm_size(cmd_word_size_i);
                        remain_q   <= cmd_count_i;
                        err_q      <= 1'b0;
                        err_addr_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (biu_rdy_i) begin
                        if (biu_err_i && !err_q) begin
                            err_q      <= 1'b1;
                            err_addr_q <= addr_q;
                        end
                        // Wraps naturally at 2^32.
                        addr_q   <= addr_q + {29'd0, size_q};
                        remain_q <= remain_q - CNT_W'(1);
                        if (rd_wrn_q) rd_data_q <= mask_rd(biu_data_i, size_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o     = (state_q == ST_IDLE);
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_DONE);
    assign rd_valid_o      = (state_q == ST_PUSH);
    assign rd_data_o       = rd_data_q;
    assign biu_strobe_o    = strobe;
    assign wr_ready_o      = strobe & ~rd_wrn_q;
    assign biu_data_o      = (state_q == ST_ISSUE) ? justify_wr(wr_data_i, size_q) : 32'h0;
    assign biu_addr_o      = addr_q;
    assign biu_rd_wrn_o    = rd_wrn_q;
    assign biu_word_size_o = size_q;
    assign err_o           = err_q;
    assign err_addr_o      = err_addr_q;

endmodule

// File: tb/tb_adbg_wb_burst_ctrl.sv
module tb_adbg_wb_burst_ctrl;

    localparam int CNT_W = 16;
`ifdef ADBG_BURST_ABORT_ON_ERR_EN
    localparam int EXP_ERR_STROBES = 2;
`else
    localparam int EXP_ERR_STROBES = 4;
`endif

    logic             tck = 1'b0;
    logic             rstn_i = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [31:0]      cmd_addr_i = '0;
    logic             cmd_rd_wrn_i = 1'b0;
    logic [2:0]       cmd_word_size_i = '0;
    logic [CNT_W-1:0] cmd_count_i = '0;
    logic [31:0]      wr_data_i = '0;
    logic             wr_valid_i = 1'b0;
    logic             wr_ready_o;
    logic [31:0]      rd_data_o;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic [31:0]      biu_data_o;
    logic [31:0]      biu_data_i = '0;
    logic [31:0]      biu_addr_o;
    logic             biu_rd_wrn_o;
    logic [2:0]       biu_word_size_o;
    logic             biu_strobe_o;
    logic             biu_rdy_i = 1'b1;
    logic             biu_err_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [31:0]      err_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    adbg_wb_burst_ctrl #(.CNT_W(CNT_W)) dut (
        .tck_i(tck), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_rd_wrn_i(cmd_rd_wrn_i), .cmd_word_size_i(cmd_word_size_i), .cmd_count_i(cmd_count_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .biu_data_o(biu_data_o), .biu_data_i(biu_data_i), .biu_addr_o(biu_addr_o),
        .biu_rd_wrn_o(biu_rd_wrn_o), .biu_word_size_o(biu_word_size_o), .biu_strobe_o(biu_strobe_o),
        .biu_rdy_i(biu_rdy_i), .biu_err_i(biu_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o)
    );

    always #5 tck = ~tck;

    // BIU model and monitors, all on the falling edge.
    int          strobe_cnt = 0;
    int          done_cnt   = 0;
    int          rd_cnt     = 0;
    logic [31:0] s_addr [0:63];
    logic [31:0] s_data [0:63];
    logic [2:0]  s_size [0:63];
    logic        s_rdwrn[0:63];
    logic [31:0] rd_log [0:63];
    logic [31:0] resp_data[0:63];
    logic        resp_err [0:63];
    int          biu_lat    = 2;
    bit          start_pend = 1'b0;
    int          lat_cnt    = 0;
    int          cur        = 0;
    logic [31:0] wq[0:7];

    always @(negedge tck) begin
        bit stb;
        stb = biu_strobe_o;
        if (done_o) done_cnt++;
        if (rd_valid_o && rd_ready_i) begin
            rd_log[rd_cnt % 64] = rd_data_o;
            rd_cnt++;
        end
        if (start_pend) begin
            start_pend = 1'b0;
            biu_rdy_i  = 1'b0;
            biu_err_i  = 1'b0;
            lat_cnt    = biu_lat - 1;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                biu_rdy_i  = 1'b1;
                biu_data_i = resp_data[cur % 64];
                biu_err_i  = resp_err[cur % 64];
            end
        end
        if (stb) begin
            s_addr[strobe_cnt % 64]  = biu_addr_o;
            s_data[strobe_cnt % 64]  = biu_data_o;
            s_size[strobe_cnt % 64]  = biu_word_size_o;
            s_rdwrn[strobe_cnt % 64] = biu_rd_wrn_o;
            cur        = strobe_cnt;
            strobe_cnt++;
            start_pend = 1'b1;
        end
    end

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic rw, input logic [2:0] sz,
                            input logic [CNT_W-1:0] cnt);
        cmd_addr_i      = a;
        cmd_rd_wrn_i    = rw;
        cmd_word_size_i = sz;
        cmd_count_i     = cnt;
        cmd_valid_i     = 1'b1;
        step();
        cmd_valid_i     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        int t = 0;
        while (done_cnt == d0 && t < budget) begin
            step();
            t++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic wait_rd_valid(input int budget, output bit ok);
        int t = 0;
        while (rd_valid_o !== 1'b1 && t < budget) begin
            step();
            t++;
        end
        ok = (rd_valid_o === 1'b1);
    endtask

    // Feeds wq[] as write words until the burst completes or the budget expires.
    task automatic drive_write(input int n, input int budget, output bit ok);
        int base = strobe_cnt;
        int d0   = done_cnt;
        int t    = 0;
        int k;
        wr_data_i  = wq[0];
        wr_valid_i = 1'b1;
        while (done_cnt == d0 && t < budget) begin
            step();
            t++;
            k = strobe_cnt - base;
            if (k < n) wr_data_i = wq[k];
            else       wr_valid_i = 1'b0;
        end
        wr_valid_i = 1'b0;
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        step();
        step();
        n_checks++;
        if ({cmd_ready_o, busy_o, done_o, err_o, rd_valid_o, biu_strobe_o, wr_ready_o, biu_rd_wrn_o} !== 8'b1000_0000)
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {cmd_ready_o, busy_o, done_o, err_o, rd_valid_o, biu_strobe_o, wr_ready_o, biu_rd_wrn_o});
        else n_pass++;
        n_checks++;
        if ({biu_addr_o, err_addr_o, rd_data_o, biu_data_o} !== 128'h0)
            $display("FAIL reset_data: got %h %h %h %h expected all zero", biu_addr_o, err_addr_o, rd_data_o, biu_data_o);
        else n_pass++;
        n_checks++;
        if (biu_word_size_o !== 3'd0)
            $display("FAIL reset_size: got %0d expected 0", biu_word_size_o);
        else n_pass++;
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_write_burst();
        int base = strobe_cnt;
        int d0   = done_cnt;
        bit ok;
        biu_lat = 2;
        wq[0] = 32'hA; wq[1] = 32'hB; wq[2] = 32'hC;
        send_cmd(32'h1000, 1'b0, 3'd4, 16'd3);
        drive_write(3, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL wr4_done_timeout: got no done expected done");
        else n_pass++;
        n_checks++;
        if (strobe_cnt - base !== 3) $display("FAIL wr4_strobes: got %0d expected 3", strobe_cnt - base);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (s_addr[base + i] !== 32'h1000 + 32'(4 * i) || s_data[base + i] !== wq[i])
                $display("FAIL wr4_word%0d: got addr %h data %h expected addr %h data %h",
                         i, s_addr[base + i], s_data[base + i], 32'h1000 + 32'(4 * i), wq[i]);
            else n_pass++;
        end
        step();
        n_checks++;
        if (done_cnt - d0 !== 1 || err_o !== 1'b0)
            $display("FAIL wr4_done_err: got done %0d err %b expected done 1 err 0", done_cnt - d0, err_o);
        else n_pass++;
    endtask

    task automatic test_read_stall();
        int base = strobe_cnt;
        int d0   = done_cnt;
        bit ok;
        bit stable = 1'b1;
        resp_data[base % 64]       = 32'hFFFFFF5A;
        resp_data[(base + 1) % 64] = 32'h123456C3;
        rd_ready_i = 1'b0;
        send_cmd(32'h2001, 1'b1, 3'd1, 16'd2);
        wait_rd_valid(50, ok);
        n_checks++;
        if (!ok || rd_data_o !== 32'h0000005A)
            $display("FAIL rd1_word0: got valid %b data %h expected valid 1 data 0000005a", rd_valid_o, rd_data_o);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h0000005A) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL rd1_stall_hold: got data %h valid %b expected 0000005a held", rd_data_o, rd_valid_o);
        else n_pass++;
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
        n_checks++;
        if (rd_valid_o !== 1'b0) $display("FAIL rd1_valid_drop: got %b expected 0", rd_valid_o);
        else n_pass++;
        wait_rd_valid(50, ok);
        n_checks++;
        if (!ok || rd_data_o !== 32'h000000C3)
            $display("FAIL rd1_word1: got valid %b data %h expected valid 1 data 000000c3", rd_valid_o, rd_data_o);
        else n_pass++;
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
        wait_done(d0, 20, ok);
        n_checks++;
        if (!ok || strobe_cnt - base !== 2 || s_addr[base % 64] !== 32'h2001 || s_addr[(base + 1) % 64] !== 32'h2002)
            $display("FAIL rd1_addrs: got n %0d %h %h expected n 2 00002001 00002002",
                     strobe_cnt - base, s_addr[base % 64], s_addr[(base + 1) % 64]);
        else n_pass++;
        n_checks++;
        if (s_size[base % 64] !== 3'd1 || s_rdwrn[base % 64] !== 1'b1)
            $display("FAIL rd1_attr: got size %0d rdwrn %b expected size 1 rdwrn 1", s_size[base % 64], s_rdwrn[base % 64]);
        else n_pass++;
    endtask

    task automatic test_write_half_gap();
        int base = strobe_cnt;
        int d0   = done_cnt;
        int t    = 0;
        bit ok;
        bit quiet = 1'b1;
        int sc;
        wr_data_i  = 32'h0000BEEF;
        wr_valid_i = 1'b1;
        send_cmd(32'h4000, 1'b0, 3'd2, 16'd2);
        while (strobe_cnt == base && t < 50) begin
            step();
            t++;
        end
        wr_valid_i = 1'b0;
        sc = strobe_cnt;
        for (int i = 0; i < 4; i++) begin
            step();
            if (biu_strobe_o !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet || strobe_cnt !== sc || sc - base !== 1)
            $display("FAIL wr2_gap: got strobes %0d quiet %b expected 1 strobe, quiet 1", strobe_cnt - base, quiet);
        else n_pass++;
        wr_data_i  = 32'h00001234;
        wr_valid_i = 1'b1;
        t = 0;
        while (strobe_cnt == sc && t < 50) begin
            step();
            t++;
        end
        wr_valid_i = 1'b0;
        wait_done(d0, 50, ok);
        n_checks++;
        if (!ok || s_data[base % 64] !== 32'hBEEF0000 || s_data[(base + 1) % 64] !== 32'h12340000)
            $display("FAIL wr2_data: got %h %h expected beef0000 12340000", s_data[base % 64], s_data[(base + 1) % 64]);
        else n_pass++;
        n_checks++;
        if (s_addr[base % 64] !== 32'h4000 || s_addr[(base + 1) % 64] !== 32'h4002)
            $display("FAIL wr2_addrs: got %h %h expected 00004000 00004002", s_addr[base % 64], s_addr[(base + 1) % 64]);
        else n_pass++;
    endtask

    task automatic test_addr_wrap();
        int base  = strobe_cnt;
        int rbase = rd_cnt;
        int d0    = done_cnt;
        bit ok;
        resp_data[base % 64]       = 32'hDEADBEEF;
        resp_data[(base + 1) % 64] = 32'h01234567;
        rd_ready_i = 1'b1;
        send_cmd(32'hFFFFFFFC, 1'b1, 3'd4, 16'd2);
        wait_done(d0, 100, ok);
        rd_ready_i = 1'b0;
        n_checks++;
        if (!ok || s_addr[base % 64] !== 32'hFFFFFFFC || s_addr[(base + 1) % 64] !== 32'h00000000)
            $display("FAIL wrap_addrs: got %h %h expected fffffffc 00000000", s_addr[base % 64], s_addr[(base + 1) % 64]);
        else n_pass++;
        n_checks++;
        if (rd_cnt - rbase !== 2 || rd_log[rbase % 64] !== 32'hDEADBEEF || rd_log[(rbase + 1) % 64] !== 32'h01234567)
            $display("FAIL wrap_rdata: got n %0d %h %h expected n 2 deadbeef 01234567",
                     rd_cnt - rbase, rd_log[rbase % 64], rd_log[(rbase + 1) % 64]);
        else n_pass++;
    endtask

    task automatic test_error();
        int base = strobe_cnt;
        int d0   = done_cnt;
        bit ok;
        resp_err[(base + 1) % 64] = 1'b1;
        resp_err[(base + 3) % 64] = 1'b1;
        wq[0] = 32'h11; wq[1] = 32'h22; wq[2] = 32'h33; wq[3] = 32'h44;
        send_cmd(32'h3000, 1'b0, 3'd4, 16'd4);
        drive_write(4, 200, ok);
        step();
        resp_err[(base + 1) % 64] = 1'b0;
        resp_err[(base + 3) % 64] = 1'b0;
        n_checks++;
        if (!ok || strobe_cnt - base !== EXP_ERR_STROBES || done_cnt - d0 !== 1)
            $display("FAIL err_strobes: got strobes %0d done %0d expected strobes %0d done 1",
                     strobe_cnt - base, done_cnt - d0, EXP_ERR_STROBES);
        else n_pass++;
        n_checks++;
        if (err_o !== 1'b1 || err_addr_o !== 32'h3004)
            $display("FAIL err_capture: got err %b addr %h expected err 1 addr 00003004", err_o, err_addr_o);
        else n_pass++;
    endtask

    task automatic test_count_zero();
        int base = strobe_cnt;
        send_cmd(32'h6000, 1'b0, 3'd4, 16'd0);
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1)
            $display("FAIL cnt0_done: got done %b busy %b expected done 1 busy 1", done_o, busy_o);
        else n_pass++;
        n_checks++;
        if (err_o !== 1'b0 || err_addr_o !== 32'h0)
            $display("FAIL cnt0_err_clear: got err %b addr %h expected err 0 addr 00000000", err_o, err_addr_o);
        else n_pass++;
        step();
        n_checks++;
        if (done_o !== 1'b0 || cmd_ready_o !== 1'b1 || strobe_cnt !== base)
            $display("FAIL cnt0_after: got done %b ready %b strobes %0d expected done 0 ready 1 strobes 0",
                     done_o, cmd_ready_o, strobe_cnt - base);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base = strobe_cnt;
        int t    = 0;
        int d0;
        biu_lat    = 5;
        wr_data_i  = 32'h55;
        wr_valid_i = 1'b1;
        send_cmd(32'h5000, 1'b0, 3'd4, 16'd2);
        while (strobe_cnt == base && t < 50) begin
            step();
            t++;
        end
        step();
        d0 = done_cnt;
        rstn_i = 1'b0;
        step();
        n_checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || biu_addr_o !== 32'h0)
            $display("FAIL rstmid_idle: got ready %b busy %b addr %h expected ready 1 busy 0 addr 00000000",
                     cmd_ready_o, busy_o, biu_addr_o);
        else n_pass++;
        rstn_i     = 1'b1;
        wr_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (done_cnt !== d0 || strobe_cnt - base !== 1)
            $display("FAIL rstmid_quiet: got done %0d strobes %0d expected done 0 strobes 1",
                     done_cnt - d0, strobe_cnt - base);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            resp_data[i] = '0;
            resp_err[i]  = 1'b0;
        end
        test_reset();
        test_write_burst();
        test_read_stall();
        test_write_half_gap();
        test_addr_wrap();
        test_error();
        test_count_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adbg_wb_burst_ctrl.md
Name: adbg_wb_burst_ctrl

Overview:
- Burst command engine in the TCK domain; sits directly upstream of the WishBone bus interface unit and drives its strobe/ready handshake.
- Accepts one burst command (start address, word size, word count, direction) and issues one single-word BIU access per word.
- Streams write words in from, and read words out to, the JTAG shift/CRC logic.
- Auto-increments the address, justifies short words to the BIU conventions, and records the first bus error.

Parameters:
- CNT_W, 16, width of word-count field and internal remaining-word counter.

Ports:
- tck_i  in  1  clock; single clock domain.
- rstn_i  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i; high only in IDLE.
- cmd_addr_i  in  32  start byte address.
- cmd_rd_wrn_i  in  1  1 = read burst, 0 = write burst.
- cmd_word_size_i  in  3  bytes per word: 1, 2 or 4; any other value is treated as 4.
- cmd_count_i  in  CNT_W  number of words.
- wr_data_i  in  32  write word, LSB-justified.
- wr_valid_i  in  1  write word valid.
- wr_ready_o  out  1  write word consumed this cycle.
- rd_data_o  out  32  read word, LSB-justified, upper bits zero.
- rd_valid_o  out  1  read word valid.
- rd_ready_i  in  1  consumer accepts read word.
- biu_data_o  out  32  to BIU data_i; short words in upper bits.
- biu_data_i  in  32  from BIU data_o; short words in lower bits.
- biu_addr_o  out  32  to BIU addr_i.
- biu_rd_wrn_o  out  1  to BIU rd_wrn_i.
- biu_word_size_o  out  3  to BIU word_size_i.
- biu_strobe_o  out  1  to BIU strobe_i; single-cycle.
- biu_rdy_i  in  1  from BIU rdy_o.
- biu_err_i  in  1  from BIU err_o.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when a burst ends.
- err_o  out  1  sticky error flag for the current/last burst.
- err_addr_o  out  32  address of the first errored word.

Behaviour:
- Reset (rstn_i low at a tck_i edge): state IDLE. All outputs 0 except cmd_ready_o = 1. Address, count, rd_data and error registers cleared. Reset mid-burst abandons the burst immediately; no done_o pulse.
- States: IDLE, ISSUE, WAIT, PUSH, DONE.
- IDLE, on cmd_valid_i:
  - latch addr, rd_wrn, normalised word size, and count;
  - clear err_o and err_addr_o;
  - go to ISSUE, or to DONE if count = 0 (no BIU access).
- ISSUE:
  - biu_strobe_o = biu_rdy_i & (read | wr_valid_i); combinational.
  - For writes, wr_ready_o equals biu_strobe_o.
  - On strobe go to WAIT. Otherwise stay; BIU busy after reset is tolerated.
- WAIT (first cycle sees biu_rdy_i = 0 by the BIU contract): on biu_rdy_i = 1 the access is complete.
  - If biu_err_i = 1 and err_o = 0: set err_o and capture err_addr_o = current address.
  - Increment address by word size, modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000). Decrement remaining.
  - Read: register masked data, set rd_valid_o, go to PUSH.
  - Write: go to DONE if remaining becomes 0, else ISSUE.
- PUSH: rd_data_o/rd_valid_o held stable until rd_ready_i. On accept, rd_valid_o drops and the state goes to DONE if remaining = 0, else ISSUE.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- Write justification:
  - size 1: biu_data_o = {wr_data_i[7:0], 24'h0}
  - size 2: biu_data_o = {wr_data_i[15:0], 16'h0}
  - size 4: pass-through
- Read masking:
  - size 1: rd_data = {24'h0, biu_data_i[7:0]}
  - size 2: rd_data = {16'h0, biu_data_i[15:0]}
  - size 4: pass-through
- Unaligned addresses are passed through unmodified; the BIU derives byte selects from them.
- biu_addr_o, biu_rd_wrn_o, biu_word_size_o are driven from latched registers, stable from ISSUE through WAIT.
- Errors do not suppress read data: an errored read still produces a word, so the word count seen by the consumer is preserved.
- Count arithmetic is CNT_W bits wide. The maximum count of 2^CNT_W−1 words is supported.

Optional Feature:
- Macro: ADBG_BURST_ABORT_ON_ERR_EN.
- Defined: a completed access with biu_err_i = 1 ends the burst.
  - Write: go to DONE.
  - Read: go to PUSH, deliver the errored word, then DONE.
  - No further strobes are issued; unconsumed write words remain upstream.
- Undefined: the burst always runs the full count; err_o and err_addr_o still record the first error.

Test Plan:
- Write, addr 0x1000, size 4, count 3, words 0xA, 0xB, 0xC, BIU 2-cycle latency → 3 strobes at addresses 0x1000/0x1004/0x1008, biu_data_o = 0xA/0xB/0xC, one done_o pulse, err_o = 0.
- Read, addr 0x2001, size 1, count 2, biu_data_i = 0xFFFFFF5A then 0x123456C3, rd_ready_i held low 3 cycles → rd_data_o = 0x5A then 0xC3, held stable while stalled, addresses 0x2001 and 0x2002.
- Write, size 2, wr_data_i = 0x0000BEEF → biu_data_o = 0xBEEF0000; address steps by 2; wr_valid_i low for 4 cycles → no strobe during the gap.
- Read, addr 0xFFFFFFFC, size 4, count 2 → second access at address 0x00000000.
- Write, count 4, biu_err_i on word 2 (addr 0x3004) → err_o = 1, err_addr_o = 0x3004; with the macro: 2 strobes then done_o; without: 4 strobes then done_o.
- Count 0 → done_o the cycle after accept, no strobe. Reset asserted in WAIT → IDLE next edge, cmd_ready_o = 1, no done_o.
